// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle FETCH/EXEC/MEM controller with flags, call depth and traps
module multicycle_controller #(
  parameter int INSTR_W     = 19,
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 8,
  parameter int MEM_TIMEOUT = 16,
  localparam int SD_W       = $clog2(STACK_DEPTH + 1),
  localparam int TO_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               zero_in,
  input  logic               carry_in,
  input  logic               mem_ack,
  output logic [2:0]         alu_fn,
  output logic               alu_src_imm,
  output logic               r2_alt,
  output logic [1:0]         wb_sel,
  output logic [1:0]         sh_fn,
  output logic               reg_write,
  output logic               mem_req,
  output logic               mem_we,
  output logic               pc_en,
  output logic [1:0]         pc_sel,
  output logic               push,
  output logic               pop,
  output logic               flag_z,
  output logic               flag_c,
  output logic [SD_W-1:0]    stack_depth,
  output logic               fault
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;
  localparam logic [1:0] S_TRAP  = 2'd3;

  logic [1:0]      state;
  logic [5:0]      op;
  logic [TO_W-1:0] tmo;

  // Only the opcode is latched; address/register fields go straight to the datapath.
  logic unused_fields;
  assign unused_fields = ^{instr[INSTR_W-7:0], ADDR_W[0]};

  logic is_alu, is_shift, is_load, is_store, is_branch, is_jmp, is_call, is_ret;
  logic full, empty, taken;

  assign is_alu    = ~op[5];
  assign is_shift  = (op[5:3] == 3'b110);
  assign is_load   = (op[5:1] == 5'b10000);
  assign is_store  = (op[5:1] == 5'b10001);
  assign is_branch = (op[5:3] == 3'b101);
  assign is_jmp    = (op[5:1] == 5'b11100);
  assign is_call   = (op[5:1] == 5'b11101);
  assign is_ret    = (op == 6'b111100);
  assign full      = (stack_depth == SD_W'(STACK_DEPTH));
  assign empty     = (stack_depth == '0);
  assign fault     = (state == S_TRAP);

  always_comb begin
    case (op[2:1])
      2'b00:   taken = flag_z;
      2'b01:   taken = ~flag_z;
      2'b10:   taken = flag_c;
      default: taken = ~flag_c;
    endcase
  end

  // Outputs are decoded from state, the latched opcode and (in MEM) the live ack.
  always_comb begin
    instr_ready = 1'b0;
    alu_fn      = 3'b000;
    alu_src_imm = 1'b0;
    r2_alt      = 1'b0;
    wb_sel      = 2'b00;
    sh_fn       = 2'b00;
    reg_write   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = 2'b00;
    push        = 1'b0;
    pop         = 1'b0;
    case (state)
      S_FETCH: instr_ready = 1'b1;
      S_EXEC: begin
        if (is_alu) begin
          alu_fn      = op[3:1];
          alu_src_imm = op[4];
          reg_write   = 1'b1;
          pc_en       = 1'b1;
        end else if (is_shift) begin
          sh_fn     = op[2:1];
          wb_sel    = 2'b01;
          reg_write = 1'b1;
          pc_en     = 1'b1;
        end else if (is_branch) begin
          pc_en  = 1'b1;
          pc_sel = taken ? 2'b01 : 2'b00;
        end else if (is_jmp) begin
          pc_en  = 1'b1;
          pc_sel = 2'b10;
        end else if (is_call && !full) begin
          push   = 1'b1;
          pc_en  = 1'b1;
          pc_sel = 2'b10;
        end else if (is_ret && !empty) begin
          pop    = 1'b1;
          pc_en  = 1'b1;
          pc_sel = 2'b11;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        r2_alt  = is_store;
        wb_sel  = 2'b10;
        if (mem_ack) begin
          reg_write = is_load;
          pc_en     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_FETCH;
      op          <= 6'd0;
      tmo         <= '0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      stack_depth <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          tmo <= '0;
          if (instr_valid) begin
            op    <= instr[INSTR_W-1 -: 6];
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_FETCH;
          if (is_alu) begin
            flag_z <= zero_in;
            flag_c <= carry_in;
          end else if (is_shift) begin
            flag_z <= zero_in;
          end else if (is_load || is_store) begin
            state <= S_MEM;
          end else if (is_call) begin
            if (full) state <= S_TRAP;
            else stack_depth <= stack_depth + 1'b1;
          end else if (is_ret) begin
            if (empty) state <= S_TRAP;
            else stack_depth <= stack_depth - 1'b1;
          end else if (!is_branch && !is_jmp) begin
            state <= S_TRAP;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            state <= S_FETCH;
          end else if (tmo == TO_W'(MEM_TIMEOUT - 1)) begin
            state <= S_TRAP;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: state <= S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [18:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        zero_in = 1'b0;
  logic        carry_in = 1'b0;
  logic        mem_ack = 1'b0;
  logic [2:0]  alu_fn;
  logic        alu_src_imm, r2_alt, reg_write, mem_req, mem_we, pc_en, push, pop;
  logic [1:0]  wb_sel, sh_fn, pc_sel;
  logic        flag_z, flag_c, fault;
  logic [3:0]  stack_depth;

  multicycle_controller dut (
    .clock(clock), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .zero_in(zero_in), .carry_in(carry_in), .mem_ack(mem_ack),
    .alu_fn(alu_fn), .alu_src_imm(alu_src_imm), .r2_alt(r2_alt), .wb_sel(wb_sel),
    .sh_fn(sh_fn), .reg_write(reg_write), .mem_req(mem_req), .mem_we(mem_we),
    .pc_en(pc_en), .pc_sel(pc_sel), .push(push), .pop(pop), .flag_z(flag_z),
    .flag_c(flag_c), .stack_depth(stack_depth), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] op;
    logic       z, c;
    logic       rw, pe;
    logic [1:0] ps, wb, sh;
    logic [2:0] fn;
    logic       imm, fz, fc;
  } vec_t;

  vec_t vecs[12];
  vec_t sbq[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic z, input logic c,
                              input logic rw, input logic pe, input logic [1:0] ps,
                              input logic [1:0] wb, input logic [1:0] sh, input logic [2:0] fn,
                              input logic imm, input logic fz, input logic fc);
    vec_t v;
    v.op = op; v.z = z; v.c = c; v.rw = rw; v.pe = pe; v.ps = ps; v.wb = wb;
    v.sh = sh; v.fn = fn; v.imm = imm; v.fz = fz; v.fc = fc;
    return v;
  endfunction

  // Advance to the next falling edge with all inputs returned to idle.
  task automatic tick();
    @(negedge clock);
    instr_valid = 1'b0;
    zero_in = 1'b0;
    carry_in = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic issue(input logic [5:0] op);
    tick();
    instr = {op, 13'h0abc};
    instr_valid = 1'b1;
    #2;
    chk("instr_ready_fetch", instr_ready, 1);
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    #2;
    tick();
    reset_n = 1'b1;
    #2;
  endtask

  initial begin
    vecs[0]  = mk(6'b000000, 1, 1, 1, 1, 2'b00, 2'b00, 2'b00, 3'd0, 0, 1, 1);
    vecs[1]  = mk(6'b101000, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'd0, 0, 1, 1);
    vecs[2]  = mk(6'b101010, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, 0, 1, 1);
    vecs[3]  = mk(6'b101100, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'd0, 0, 1, 1);
    vecs[4]  = mk(6'b101110, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, 0, 1, 1);
    vecs[5]  = mk(6'b010110, 0, 1, 1, 1, 2'b00, 2'b00, 2'b00, 3'd3, 1, 0, 1);
    vecs[6]  = mk(6'b110100, 1, 0, 1, 1, 2'b00, 2'b01, 2'b10, 3'd0, 0, 1, 1);
    vecs[7]  = mk(6'b101110, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, 0, 1, 1);
    vecs[8]  = mk(6'b001110, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 3'd7, 0, 0, 0);
    vecs[9]  = mk(6'b101010, 1, 1, 0, 1, 2'b01, 2'b00, 2'b00, 3'd0, 0, 0, 0);
    vecs[10] = mk(6'b111000, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 3'd0, 0, 0, 0);
    vecs[11] = mk(6'b101100, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, 0, 0, 0);

    // Reset state
    #2;
    chk("rst_ready", instr_ready, 1);
    chk("rst_strobes", {reg_write, mem_req, pc_en, push, pop}, 0);
    chk("rst_selects", {alu_fn, alu_src_imm, r2_alt, wb_sel, sh_fn, mem_we, pc_sel}, 0);
    chk("rst_state", {flag_z, flag_c, stack_depth, fault}, 0);
    tick();
    reset_n = 1'b1;

    // Stray mem_ack in FETCH is ignored
    tick();
    mem_ack = 1'b1;
    #2;
    chk("stray_ack_pc_en", pc_en, 0);
    chk("stray_ack_rw", reg_write, 0);

    foreach (vecs[i]) begin
      issue(vecs[i].op);
      sbq.push_back(vecs[i]);
      tick();
      zero_in = vecs[i].z;
      carry_in = vecs[i].c;
      #2;
      if (sbq.size() == 0) begin
        chk("sb_underflow", 0, 1);
      end else begin
        vec_t e;
        e = sbq.pop_front();
        chk($sformatf("v%0d_reg_write", i), reg_write, e.rw);
        chk($sformatf("v%0d_pc_en", i), pc_en, e.pe);
        chk($sformatf("v%0d_pc_sel", i), pc_sel, e.ps);
        chk($sformatf("v%0d_wb_sel", i), wb_sel, e.wb);
        chk($sformatf("v%0d_sh_fn", i), sh_fn, e.sh);
        chk($sformatf("v%0d_alu_fn", i), alu_fn, e.fn);
        chk($sformatf("v%0d_imm", i), alu_src_imm, e.imm);
        chk($sformatf("v%0d_pushpop_mem", i), {push, pop, mem_req}, 0);
        tick();
        #2;
        chk($sformatf("v%0d_pc_en_once", i), pc_en, 0);
        chk($sformatf("v%0d_flag_z", i), flag_z, e.fz);
        chk($sformatf("v%0d_flag_c", i), flag_c, e.fc);
        chk($sformatf("v%0d_ready", i), instr_ready, 1);
      end
    end
    chk("sb_empty", sbq.size(), 0);

    // LOAD with ack on the 4th MEM cycle
    begin
      int req_cyc = 0;
      issue(6'b100000);
      tick();
      instr_valid = 1'b1;
      instr = {6'b111110, 13'h0};
      #2;
      chk("load_exec_req", {mem_req, pc_en}, 0);
      for (int k = 0; k < 4; k++) begin
        tick();
        mem_ack = (k == 3);
        #2;
        if (mem_req) req_cyc++;
        chk("load_wb_sel", wb_sel, 2'b10);
        chk("load_we_r2", {mem_we, r2_alt}, 0);
        chk("load_rw", reg_write, (k == 3));
        chk("load_pc_en", pc_en, (k == 3));
      end
      chk("load_req_cycles", req_cyc, 4);
      chk("load_pc_sel", pc_sel, 0);
      tick();
      #2;
      chk("load_after_ready", instr_ready, 1);
      chk("load_after_req", mem_req, 0);
      chk("load_no_fault", fault, 0);
    end

    // STORE acked in its first MEM cycle
    issue(6'b100010);
    tick();
    #2;
    tick();
    mem_ack = 1'b1;
    #2;
    chk("store_req_we_r2", {mem_req, mem_we, r2_alt}, 3'b111);
    chk("store_rw", reg_write, 0);
    chk("store_pc_en", pc_en, 1);
    tick();
    #2;
    chk("store_back_fetch", instr_ready, 1);

    // Eight CALLs, a RET, refill, then overflow
    for (int k = 0; k < 8; k++) begin
      issue(6'b111010);
      tick();
      #2;
      chk("call_push", {push, pc_en, pc_sel}, 4'b1110);
    end
    tick();
    #2;
    chk("depth_8", stack_depth, 8);
    issue(6'b111100);
    tick();
    #2;
    chk("ret_pop", {pop, pc_en, pc_sel}, 4'b1111);
    tick();
    #2;
    chk("depth_7", stack_depth, 7);
    issue(6'b111010);
    tick();
    #2;
    issue(6'b111010);
    tick();
    #2;
    chk("call9_no_push", {push, pc_en}, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      instr_valid = 1'b1;
      #2;
      chk("ovf_fault", fault, 1);
      chk("ovf_ready", instr_ready, 0);
      chk("ovf_depth", stack_depth, 8);
    end
    do_reset();
    chk("reset_clears_fault", {fault, stack_depth}, 0);
    chk("reset_ready", instr_ready, 1);

    // RET at depth 0
    issue(6'b111100);
    tick();
    #2;
    chk("ret0_no_pop", {pop, pc_en}, 0);
    tick();
    #2;
    chk("ret0_fault", fault, 1);
    do_reset();

    // Illegal opcode
    issue(6'b111110);
    tick();
    #2;
    tick();
    #2;
    chk("illegal_fault", fault, 1);
    chk("illegal_strobes", {reg_write, pc_en, mem_req, instr_ready}, 0);
    do_reset();

    // STORE that is never acknowledged
    begin
      int req_cyc = 0;
      issue(6'b100011);
      for (int k = 0; k < 40; k++) begin
        tick();
        #2;
        if (mem_req) req_cyc++;
        else if (req_cyc > 0) break;
      end
      chk("timeout_req_cycles", req_cyc, 16);
      chk("timeout_fault", fault, 1);
      do_reset();
    end

    // Asynchronous reset in the middle of MEM
    issue(6'b100000);
    tick();
    #2;
    tick();
    #2;
    tick();
    #2;
    chk("midmem_req_before", mem_req, 1);
    reset_n = 1'b0;
    #1;
    chk("midmem_req_dropped", mem_req, 0);
    tick();
    reset_n = 1'b1;
    #2;
    chk("midmem_fetch", instr_ready, 1);
    chk("midmem_no_fault", fault, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
